// File: rtl/ifmap_row_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifmap_row_streamer                                                       |
// | Streams pixel rows from sync-read SRAM into the PE IFMap buffer, tagging |
// | each word with start/end-of-row flags. Optional ZERO_PAD_EN frames rows. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ifmap_row_streamer #(
  parameter int IFMAP_WIDTH  = 18,
  parameter int ADDR_WIDTH   = 16,
  parameter int ROW_LEN_SIZE = 8,
  parameter int ROW_CNT_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ROW_LEN_SIZE-1:0] row_len,
  input  logic [ROW_CNT_SIZE-1:0] num_rows,
  output logic                    mem_ren,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [IFMAP_WIDTH-3:0]  mem_rdata,
  input  logic                    buf_ready,
  output logic                    buf_wen,
  output logic [IFMAP_WIDTH-1:0]  buf_din,
  output logic                    busy,
  output logic                    done
);

  localparam int PIX_W = IFMAP_WIDTH - 2;
`ifdef ZERO_PAD_EN
  localparam int COL_W = ROW_LEN_SIZE + 1;
`else
  localparam int COL_W = ROW_LEN_SIZE;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ROW_LEN_SIZE-1:0] len_q, len_d;
  logic [ROW_CNT_SIZE-1:0] rows_q, rows_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_CNT_SIZE-1:0] row_q, row_d;
  logic                    infl_q, infl_d;
  logic                    infl_sor_q, infl_sor_d;
  logic                    infl_eor_q, infl_eor_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [IFMAP_WIDTH-1:0]  q0_q, q0_d;
  logic [IFMAP_WIDTH-1:0]  q1_q, q1_d;

  logic                    pop, issue, is_sor, is_eor, last_issue, room;
  logic [COL_W-1:0]        col_last;
  logic [PIX_W-1:0]        push_pix;
  logic [IFMAP_WIDTH-1:0]  push_word;

`ifdef ZERO_PAD_EN
  logic infl_pad_q, infl_pad_d;
  logic is_pad;
  // Column 0 and column row_len+1 are the synthesized zero pads.
  assign col_last = COL_W'(len_q) + COL_W'(1);
  assign is_pad   = is_sor | is_eor;
  assign mem_ren  = issue & ~is_pad;
  assign push_pix = infl_pad_q ? '0 : mem_rdata;
  assign infl_pad_d = is_pad;
`else
  assign col_last = len_q - ROW_LEN_SIZE'(1);
  assign mem_ren  = issue;
  assign push_pix = mem_rdata;
`endif

  assign pop        = (cnt_q != 2'd0) & buf_ready;
  // Occupancy after this cycle's pop must leave a slot for a new read.
  assign room       = ({1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop}) < 3'd2;
  assign issue      = (state_q == S_RUN) & room;
  assign is_sor     = (col_q == '0);
  assign is_eor     = (col_q == col_last);
  assign last_issue = issue & is_eor & (row_q == rows_q - ROW_CNT_SIZE'(1));
  assign push_word  = {infl_sor_q, infl_eor_q, push_pix};

  assign cnt_d      = cnt_q + {1'b0, infl_q} - {1'b0, pop};
  assign infl_d     = issue;
  assign infl_sor_d = is_sor;
  assign infl_eor_d = is_eor;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    rows_d  = rows_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          len_d   = row_len;
          rows_d  = num_rows;
          col_d   = '0;
          row_d   = '0;
          state_d = (row_len == '0 || num_rows == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (is_eor) begin
            col_d = '0;
            row_d = row_q + ROW_CNT_SIZE'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (mem_ren) addr_d = addr_q + ADDR_WIDTH'(1);
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (cnt_d == 2'd0) state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    q0_d = q0_q;
    q1_d = q1_q;
    if (pop) begin
      if (cnt_q == 2'd2) begin
        q0_d = q1_q;
        if (infl_q) q1_d = push_word;
      end else if (infl_q) begin
        q0_d = push_word;
      end
    end else if (infl_q) begin
      if (cnt_q == 2'd0) q0_d = push_word;
      else               q1_d = push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      rows_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      infl_q     <= 1'b0;
      infl_sor_q <= 1'b0;
      infl_eor_q <= 1'b0;
      cnt_q      <= 2'd0;
      q0_q       <= '0;
      q1_q       <= '0;
`ifdef ZERO_PAD_EN
      infl_pad_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      rows_q     <= rows_d;
      col_q      <= col_d;
      row_q      <= row_d;
      infl_q     <= infl_d;
      infl_sor_q <= infl_sor_d;
      infl_eor_q <= infl_eor_d;
      cnt_q      <= cnt_d;
      q0_q       <= q0_d;
      q1_q       <= q1_d;
`ifdef ZERO_PAD_EN
      infl_pad_q <= infl_pad_d;
`endif
    end
  end

  assign mem_addr = addr_q;
  assign buf_wen  = (cnt_q != 2'd0);
  assign buf_din  = q0_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_ifmap_row_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ifmap_row_streamer                                                    |
// | Directed self-checking bench for ifmap_row_streamer.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ifmap_row_streamer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] base_addr;
  logic [7:0]  row_len, num_rows;
  logic        mem_ren;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        buf_ready, buf_wen;
  logic [17:0] buf_din;
  logic        busy, done;

  ifmap_row_streamer #(
    .IFMAP_WIDTH(18), .ADDR_WIDTH(16), .ROW_LEN_SIZE(8), .ROW_CNT_SIZE(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .row_len(row_len), .num_rows(num_rows), .mem_ren(mem_ren),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .buf_ready(buf_ready),
    .buf_wen(buf_wen), .buf_din(buf_din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory: pixel value derived from its address.
  always @(posedge clk) if (mem_ren) mem_rdata <= mem_addr ^ 16'h5A00;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [15:0] ren_q[$];
  logic [17:0] acc_q[$];
  int          first_wen, done_cnt, done_cyc, max_out, stall_err, start_cyc;
  logic        prev_stall;
  logic [17:0] prev_din;

  always @(negedge clk) begin
    if (mem_ren) ren_q.push_back(mem_addr);
    if (buf_wen && first_wen < 0) first_wen = cyc;
    if (buf_wen && buf_ready) acc_q.push_back(buf_din);
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (ren_q.size() - acc_q.size() > max_out) max_out = ren_q.size() - acc_q.size();
    if (prev_stall && buf_din !== prev_din) stall_err++;
    prev_stall = buf_wen && !buf_ready;
    prev_din   = buf_din;
  end

  task automatic clear_mon();
    ren_q.delete();
    acc_q.delete();
    first_wen = -1; done_cnt = 0; done_cyc = -1;
    max_out = 0; stall_err = 0; prev_stall = 1'b0;
  endtask

  task automatic kick(input logic [15:0] b, input logic [7:0] l, input logic [7:0] r);
    clear_mon();
    base_addr = b; row_len = l; num_rows = r; start = 1'b1; buf_ready = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: alternate 1/0 with a 6-cycle low window.
  task automatic run_xfer(input string tag, input logic [15:0] b, input logic [7:0] l,
                          input logic [7:0] r, input int mode);
    kick(b, l, r);
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      if (mode == 1) buf_ready = (k >= 4 && k < 10) ? 1'b0 : (k % 2 == 0);
      else           buf_ready = 1'b1;
      @(posedge clk); #1;
    end
    buf_ready = 1'b1;
    check_eq({tag, "_done_seen"}, done_cnt != 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_xfer(input string tag, input logic [15:0] b, input logic [7:0] l,
                            input logic [7:0] r);
    logic [17:0] exp_w[$];
    logic [15:0] exp_a[$];
    logic [15:0] a;
    a = b;
    if (l != 0 && r != 0) begin
      for (int ri = 0; ri < r; ri++) begin
`ifdef ZERO_PAD_EN
        exp_w.push_back({2'b10, 16'h0000});
`endif
        for (int ci = 0; ci < l; ci++) begin
`ifdef ZERO_PAD_EN
          exp_w.push_back({2'b00, a ^ 16'h5A00});
`else
          exp_w.push_back({ci == 0, ci == l - 1, a ^ 16'h5A00});
`endif
          exp_a.push_back(a);
          a = a + 16'd1;
        end
`ifdef ZERO_PAD_EN
        exp_w.push_back({2'b01, 16'h0000});
`endif
      end
    end
    check_eq({tag, "_nwords"}, acc_q.size(), exp_w.size());
    check_eq({tag, "_nreads"}, ren_q.size(), exp_a.size());
    for (int i = 0; i < exp_w.size() && i < acc_q.size(); i++)
      check_eq($sformatf("%s_word%0d", tag, i), acc_q[i], exp_w[i]);
    for (int i = 0; i < exp_a.size() && i < ren_q.size(); i++)
      check_eq($sformatf("%s_addr%0d", tag, i), ren_q[i], exp_a[i]);
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_busy_after"}, busy, 0);
    check_eq({tag, "_outstanding"}, max_out <= 2, 1);
    check_eq({tag, "_stall_stable"}, stall_err, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ctrl"}, {mem_ren, buf_wen, busy, done}, 4'b0000);
    check_eq({tag, "_addr"}, mem_addr, 16'h0000);
    check_eq({tag, "_din"}, buf_din, 18'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; buf_ready = 1'b1;
    base_addr = '0; row_len = '0; num_rows = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    @(posedge clk); #1;
    run_xfer("t1", 16'h0010, 8'd4, 8'd2, 0);
    check_xfer("t1", 16'h0010, 8'd4, 8'd2);
    check_eq("t1_wen_latency", first_wen - start_cyc, 2);

    run_xfer("t2", 16'h0100, 8'd1, 8'd3, 0);
    check_xfer("t2", 16'h0100, 8'd1, 8'd3);

    run_xfer("t3", 16'h0200, 8'd5, 8'd1, 1);
    check_xfer("t3", 16'h0200, 8'd5, 8'd1);

    run_xfer("t4a", 16'h0300, 8'd0, 8'd2, 0);
    check_eq("t4a_nreads", ren_q.size(), 0);
    check_eq("t4a_nwords", acc_q.size(), 0);
    check_eq("t4a_done_cnt", done_cnt, 1);
    check_eq("t4a_done_cyc", done_cyc - start_cyc, 0);
    run_xfer("t4b", 16'h0300, 8'd3, 8'd0, 0);
    check_eq("t4b_nreads", ren_q.size(), 0);
    check_eq("t4b_nwords", acc_q.size(), 0);
    check_eq("t4b_done_cyc", done_cyc - start_cyc, 0);

    // Reset in the middle of the second of three rows.
    kick(16'h0400, 8'd4, 8'd3);
    for (int k = 0; k < 100 && acc_q.size() < 5; k++) begin
      @(posedge clk); #1;
    end
    check_eq("t5_reached_row2", acc_q.size() >= 5, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("t5_after_rst");
    @(posedge clk); #1;
    run_xfer("t5r", 16'h0500, 8'd3, 8'd2, 0);
    check_xfer("t5r", 16'h0500, 8'd3, 8'd2);

`ifdef ZERO_PAD_EN
    run_xfer("t6", 16'h0600, 8'd2, 8'd1, 0);
    check_xfer("t6", 16'h0600, 8'd2, 8'd1);
`else
    run_xfer("t6", 16'hFFFF, 8'd3, 8'd1, 0);
    check_xfer("t6", 16'hFFFF, 8'd3, 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
